// File: rtl/dds_serial_slave.sv
// dds_serial_slave: responder model of the AD9958 serial port.
// Decodes instruction bytes and register payloads in 1-bit and 4-bit serial
// modes and keeps per-channel buffered registers. The buffers are copied to
// the active outputs on a rising io_update.
// Optional feature macro: DDS_SLAVE_READBACK_EN adds the sdo/sdo_oe readback
// path. Without it, every read instruction is a protocol error.
module dds_serial_slave #(
  parameter int SCLK_MIN_PHASE = 1
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        dds_reset,
  input  logic        sclk,
  input  logic        cs,
  input  logic [3:0]  sdio,
  input  logic        io_update,
  output logic [7:0]  csr,
  output logic [23:0] fr1,
  output logic [23:0] cfr0,
  output logic [23:0] cfr1,
  output logic [31:0] cftw0,
  output logic [31:0] cftw1,
  output logic [15:0] cpow0,
  output logic [15:0] cpow1,
  output logic [23:0] acr0,
  output logic [23:0] acr1,
  output logic        four_bit_mode,
  output logic        update_pulse,
  output logic        proto_error
`ifdef DDS_SLAVE_READBACK_EN
  ,
  output logic        sdo,
  output logic        sdo_oe
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INSTR   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_DISCARD = 3'd3;
`ifdef DDS_SLAVE_READBACK_EN
  localparam logic [2:0] ST_READ    = 3'd4;
`endif

  localparam logic [7:0]  CSR_RST = 8'hF0;
  localparam logic [23:0] CFR_RST = 24'h000302;

  // Payload length in bytes for each register address; 0 marks an invalid address.
  function automatic logic [2:0] reg_len(input logic [4:0] addr);
    case (addr)
      5'h00:   reg_len = 3'd1;
      5'h01:   reg_len = 3'd3;
      5'h03:   reg_len = 3'd3;
      5'h04:   reg_len = 3'd4;
      5'h05:   reg_len = 3'd2;
      5'h06:   reg_len = 3'd3;
      default: reg_len = 3'd0;
    endcase
  endfunction

  // Edge history and FSM state
  logic        sclk_q_r, cs_q_r, io_update_q_r;
  logic [2:0]  state_r;
  logic [7:0]  shift_r;
  logic [3:0]  bit_cnt_r;
  logic [2:0]  byte_cnt_r;
  logic [2:0]  len_r;
  logic [4:0]  addr_r;
  logic [31:0] asm_r;
  logic [1:0]  ch_en_r;
  logic [7:0]  phase_cnt_r;
  logic        proto_error_r, four_bit_mode_r, update_pulse_r;

  // Active and buffered registers
  logic [7:0]  csr_r;
  logic [23:0] fr1_r, cfr0_r, cfr1_r, acr0_r, acr1_r;
  logic [31:0] cftw0_r, cftw1_r;
  logic [15:0] cpow0_r, cpow1_r;
  logic [23:0] fr1_buf_r, cfr0_buf_r, cfr1_buf_r, acr0_buf_r, acr1_buf_r;
  logic [31:0] cftw0_buf_r, cftw1_buf_r;
  logic [15:0] cpow0_buf_r, cpow1_buf_r;

  // Decode signals
  logic        rise_s, cs_fall_s, commit_s, phase_err_s;
  logic [2:0]  eff_state_s;
  logic [7:0]  byte_nxt_s;
  logic [3:0]  step_s;
  logic        byte_done_s, instr_done_s, reg_done_s, instr_err_s, rd_ok_s;
  logic [2:0]  len_s;
  logic [31:0] asm_nxt_s;
  logic        wr_fr1_s, wr_cfr_s, wr_cftw_s, wr_cpow_s, wr_acr_s;
  logic [23:0] fr1_buf_nxt_s, cfr0_buf_nxt_s, cfr1_buf_nxt_s, acr0_buf_nxt_s, acr1_buf_nxt_s;
  logic [31:0] cftw0_buf_nxt_s, cftw1_buf_nxt_s;
  logic [15:0] cpow0_buf_nxt_s, cpow1_buf_nxt_s;

`ifdef DDS_SLAVE_READBACK_EN
  logic [31:0] rd_shift_r;
  logic [5:0]  rd_cnt_r;
  logic        sdo_r, sdo_oe_r;
  logic        fall_s;
  logic [31:0] rd_src_s;

  // Left-align an n-byte value so its MSB leaves first.
  function automatic logic [31:0] rd_align(input logic [2:0] n, input logic [31:0] v);
    case (n)
      3'd1:    rd_align = {v[7:0], 24'd0};
      3'd2:    rd_align = {v[15:0], 16'd0};
      3'd3:    rd_align = {v[23:0], 8'd0};
      default: rd_align = v;
    endcase
  endfunction
`endif

  assign rise_s    = sclk & ~sclk_q_r & ~cs;
  assign cs_fall_s = ~cs & cs_q_r;
  assign commit_s  = io_update & ~io_update_q_r;
  assign phase_err_s = ~cs && (sclk != sclk_q_r) &&
                       ((32'(phase_cnt_r) + 32'd1) < 32'(SCLK_MIN_PHASE));

  // Serial decode: byte assembly, instruction checks and write strobes.
  always_comb begin
    eff_state_s = state_r;
    if ((state_r == ST_IDLE) && cs_fall_s) begin
      eff_state_s = ST_INSTR;
    end else begin
      eff_state_s = state_r;
    end
    if (four_bit_mode_r) begin
      byte_nxt_s  = {shift_r[3:0], sdio};
      step_s      = 4'd4;
      byte_done_s = rise_s && (bit_cnt_r == 4'd4);
    end else begin
      byte_nxt_s  = {shift_r[6:0], sdio[0]};
      step_s      = 4'd1;
      byte_done_s = rise_s && (bit_cnt_r == 4'd7);
    end
    len_s        = reg_len(byte_nxt_s[4:0]);
    instr_done_s = byte_done_s && (eff_state_s == ST_INSTR);
`ifdef DDS_SLAVE_READBACK_EN
    rd_ok_s      = (len_s != 3'd0) && ~four_bit_mode_r;
`else
    rd_ok_s      = 1'b0;
`endif
    instr_err_s  = instr_done_s && ((len_s == 3'd0) || (byte_nxt_s[7] && ~rd_ok_s));
    reg_done_s   = byte_done_s && (state_r == ST_DATA) && (byte_cnt_r == (len_r - 3'd1));
    asm_nxt_s    = {asm_r[23:0], byte_nxt_s};
    wr_fr1_s     = reg_done_s && (addr_r == 5'h01);
    wr_cfr_s     = reg_done_s && (addr_r == 5'h03);
    wr_cftw_s    = reg_done_s && (addr_r == 5'h04);
    wr_cpow_s    = reg_done_s && (addr_r == 5'h05);
    wr_acr_s     = reg_done_s && (addr_r == 5'h06);
  end

  // Next buffer contents; a commit in the same cycle picks these up.
  assign fr1_buf_nxt_s   = wr_fr1_s ? asm_nxt_s[23:0] : fr1_buf_r;
  assign cfr0_buf_nxt_s  = (wr_cfr_s && ch_en_r[0]) ? asm_nxt_s[23:0] : cfr0_buf_r;
  assign cfr1_buf_nxt_s  = (wr_cfr_s && ch_en_r[1]) ? asm_nxt_s[23:0] : cfr1_buf_r;
  assign cftw0_buf_nxt_s = (wr_cftw_s && ch_en_r[0]) ? asm_nxt_s : cftw0_buf_r;
  assign cftw1_buf_nxt_s = (wr_cftw_s && ch_en_r[1]) ? asm_nxt_s : cftw1_buf_r;
  assign cpow0_buf_nxt_s = (wr_cpow_s && ch_en_r[0]) ? asm_nxt_s[15:0] : cpow0_buf_r;
  assign cpow1_buf_nxt_s = (wr_cpow_s && ch_en_r[1]) ? asm_nxt_s[15:0] : cpow1_buf_r;
  assign acr0_buf_nxt_s  = (wr_acr_s && ch_en_r[0]) ? asm_nxt_s[23:0] : acr0_buf_r;
  assign acr1_buf_nxt_s  = (wr_acr_s && ch_en_r[1]) ? asm_nxt_s[23:0] : acr1_buf_r;

`ifdef DDS_SLAVE_READBACK_EN
  assign fall_s = ~sclk & sclk_q_r & ~cs;

  // Select the buffered value addressed by a read instruction.
  always_comb begin
    case (byte_nxt_s[4:0])
      5'h00:   rd_src_s = {24'd0, csr_r};
      5'h01:   rd_src_s = {8'd0, fr1_buf_r};
      5'h03:   rd_src_s = {8'd0, csr_r[6] ? cfr0_buf_r : cfr1_buf_r};
      5'h04:   rd_src_s = csr_r[6] ? cftw0_buf_r : cftw1_buf_r;
      5'h05:   rd_src_s = {16'd0, csr_r[6] ? cpow0_buf_r : cpow1_buf_r};
      5'h06:   rd_src_s = {8'd0, csr_r[6] ? acr0_buf_r : acr1_buf_r};
      default: rd_src_s = 32'd0;
    endcase
  end
`endif

  // Input edge history; keeps tracking during dds_reset so no false edge follows it.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sclk_q_r      <= 1'b0;
      cs_q_r        <= 1'b1;
      io_update_q_r <= 1'b0;
    end else begin
      sclk_q_r      <= sclk;
      cs_q_r        <= cs;
      io_update_q_r <= io_update;
    end
  end

  // Cycles sclk has held its current level, for the phase-length check.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      phase_cnt_r <= 8'd0;
    end else if (dds_reset) begin
      phase_cnt_r <= 8'd0;
    end else if (sclk != sclk_q_r) begin
      phase_cnt_r <= 8'd0;
    end else if (phase_cnt_r != 8'hFF) begin
      phase_cnt_r <= phase_cnt_r + 8'd1;
    end
  end

  // Serial FSM: instruction/data collection, CSR writes and error flag.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq || dds_reset) begin
      state_r         <= ST_IDLE;
      shift_r         <= 8'd0;
      bit_cnt_r       <= 4'd0;
      byte_cnt_r      <= 3'd0;
      len_r           <= 3'd0;
      addr_r          <= 5'd0;
      asm_r           <= 32'd0;
      ch_en_r         <= 2'd0;
      csr_r           <= CSR_RST;
      four_bit_mode_r <= 1'b0;
      proto_error_r   <= 1'b0;
`ifdef DDS_SLAVE_READBACK_EN
      rd_shift_r      <= 32'd0;
      rd_cnt_r        <= 6'd0;
      sdo_r           <= 1'b0;
      sdo_oe_r        <= 1'b0;
`endif
    end else begin
      proto_error_r <= proto_error_r | phase_err_s | instr_err_s;
      if (cs) begin
        // Deselect drops any partial byte or register silently.
        state_r    <= ST_IDLE;
        bit_cnt_r  <= 4'd0;
        byte_cnt_r <= 3'd0;
        shift_r    <= 8'd0;
`ifdef DDS_SLAVE_READBACK_EN
        sdo_oe_r   <= 1'b0;
`endif
      end else begin
        case (eff_state_s)
          ST_INSTR: begin
            state_r <= ST_INSTR;
            if (rise_s) begin
              shift_r <= byte_nxt_s;
              if (byte_done_s) begin
                bit_cnt_r <= 4'd0;
                if (instr_err_s) begin
                  state_r <= ST_DISCARD;
                end else if (byte_nxt_s[7]) begin
`ifdef DDS_SLAVE_READBACK_EN
                  state_r    <= ST_READ;
                  rd_shift_r <= rd_align(len_s, rd_src_s);
                  rd_cnt_r   <= {len_s, 3'b000};
                  sdo_oe_r   <= 1'b1;
`else
                  state_r    <= ST_DISCARD;
`endif
                end else begin
                  state_r    <= ST_DATA;
                  len_r      <= len_s;
                  addr_r     <= byte_nxt_s[4:0];
                  ch_en_r    <= csr_r[7:6];
                  byte_cnt_r <= 3'd0;
                  asm_r      <= 32'd0;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + step_s;
              end
            end
          end
          ST_DATA: begin
            if (rise_s) begin
              shift_r <= byte_nxt_s;
              if (byte_done_s) begin
                bit_cnt_r <= 4'd0;
                asm_r     <= asm_nxt_s;
                if (reg_done_s) begin
                  state_r    <= ST_INSTR;
                  byte_cnt_r <= 3'd0;
                  if (addr_r == 5'h00) begin
                    // CSR takes effect immediately; the new mode applies from the next byte.
                    csr_r           <= asm_nxt_s[7:0];
                    four_bit_mode_r <= (asm_nxt_s[2:1] == 2'b11);
                  end
                end else begin
                  byte_cnt_r <= byte_cnt_r + 3'd1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + step_s;
              end
            end
          end
`ifdef DDS_SLAVE_READBACK_EN
          ST_READ: begin
            if (fall_s) begin
              if (rd_cnt_r != 6'd0) begin
                sdo_r      <= rd_shift_r[31];
                rd_shift_r <= {rd_shift_r[30:0], 1'b0};
                rd_cnt_r   <= rd_cnt_r - 6'd1;
              end else begin
                sdo_oe_r <= 1'b0;
                state_r  <= ST_DISCARD;
              end
            end
          end
`endif
          default: begin
            state_r <= state_r;
          end
        endcase
      end
    end
  end

  // Buffer update every cycle and commit of the buffers to the active set.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq || dds_reset) begin
      fr1_buf_r   <= 24'd0;   fr1_r   <= 24'd0;
      cfr0_buf_r  <= CFR_RST; cfr0_r  <= CFR_RST;
      cfr1_buf_r  <= CFR_RST; cfr1_r  <= CFR_RST;
      cftw0_buf_r <= 32'd0;   cftw0_r <= 32'd0;
      cftw1_buf_r <= 32'd0;   cftw1_r <= 32'd0;
      cpow0_buf_r <= 16'd0;   cpow0_r <= 16'd0;
      cpow1_buf_r <= 16'd0;   cpow1_r <= 16'd0;
      acr0_buf_r  <= 24'd0;   acr0_r  <= 24'd0;
      acr1_buf_r  <= 24'd0;   acr1_r  <= 24'd0;
      update_pulse_r <= 1'b0;
    end else begin
      fr1_buf_r   <= fr1_buf_nxt_s;
      cfr0_buf_r  <= cfr0_buf_nxt_s;
      cfr1_buf_r  <= cfr1_buf_nxt_s;
      cftw0_buf_r <= cftw0_buf_nxt_s;
      cftw1_buf_r <= cftw1_buf_nxt_s;
      cpow0_buf_r <= cpow0_buf_nxt_s;
      cpow1_buf_r <= cpow1_buf_nxt_s;
      acr0_buf_r  <= acr0_buf_nxt_s;
      acr1_buf_r  <= acr1_buf_nxt_s;
      update_pulse_r <= commit_s;
      if (commit_s) begin
        fr1_r   <= fr1_buf_nxt_s;
        cfr0_r  <= cfr0_buf_nxt_s;
        cfr1_r  <= cfr1_buf_nxt_s;
        cftw0_r <= cftw0_buf_nxt_s;
        cftw1_r <= cftw1_buf_nxt_s;
        cpow0_r <= cpow0_buf_nxt_s;
        cpow1_r <= cpow1_buf_nxt_s;
        acr0_r  <= acr0_buf_nxt_s;
        acr1_r  <= acr1_buf_nxt_s;
      end
    end
  end

  assign csr           = csr_r;
  assign fr1           = fr1_r;
  assign cfr0          = cfr0_r;
  assign cfr1          = cfr1_r;
  assign cftw0         = cftw0_r;
  assign cftw1         = cftw1_r;
  assign cpow0         = cpow0_r;
  assign cpow1         = cpow1_r;
  assign acr0          = acr0_r;
  assign acr1          = acr1_r;
  assign four_bit_mode = four_bit_mode_r;
  assign update_pulse  = update_pulse_r;
  assign proto_error   = proto_error_r;
`ifdef DDS_SLAVE_READBACK_EN
  assign sdo           = sdo_r;
  assign sdo_oe        = sdo_oe_r;
`endif

endmodule

// File: tb/tb_dds_serial_slave.sv
// Scoreboard bench for dds_serial_slave: every io_update pushes the expected
// active register set; a monitor pops and compares on each update_pulse.
module tb_dds_serial_slave;

  logic        clk = 1'b0;
  logic        resetq, dds_reset, sclk, cs, io_update;
  logic [3:0]  sdio;
  logic [7:0]  csr;
  logic [23:0] fr1, cfr0, cfr1, acr0, acr1;
  logic [31:0] cftw0, cftw1;
  logic [15:0] cpow0, cpow1;
  logic        four_bit_mode, update_pulse, proto_error;

  always #5 clk = ~clk;

  dds_serial_slave dut (
    .clk(clk), .resetq(resetq), .dds_reset(dds_reset), .sclk(sclk), .cs(cs),
    .sdio(sdio), .io_update(io_update), .csr(csr), .fr1(fr1), .cfr0(cfr0),
    .cfr1(cfr1), .cftw0(cftw0), .cftw1(cftw1), .cpow0(cpow0), .cpow1(cpow1),
    .acr0(acr0), .acr1(acr1), .four_bit_mode(four_bit_mode),
    .update_pulse(update_pulse), .proto_error(proto_error)
  );

  typedef struct {
    logic [7:0]  csr;
    logic [23:0] fr1, cfr0, cfr1, acr0, acr1;
    logic [31:0] cftw0, cftw1;
    logic [15:0] cpow0, cpow1;
    logic        four, perr;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;

  int checks = 0;
  int errors = 0;
  int pulses_sent = 0;
  int pulses_seen = 0;
  logic prev_pulse = 1'b0;

  // Bench model: CSR, mode, error flag and buffered registers.
  logic [7:0]  m_csr;
  logic        m_four, m_perr;
  logic [23:0] b_fr1, b_cfr0, b_cfr1, b_acr0, b_acr1;
  logic [31:0] b_cftw0, b_cftw1;
  logic [15:0] b_cpow0, b_cpow1;
  logic [31:0] a_cftw0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_csr = 8'hF0; m_four = 1'b0; m_perr = 1'b0;
    b_fr1 = 24'd0; b_cfr0 = 24'h000302; b_cfr1 = 24'h000302;
    b_acr0 = 24'd0; b_acr1 = 24'd0; b_cftw0 = 32'd0; b_cftw1 = 32'd0;
    b_cpow0 = 16'd0; b_cpow1 = 16'd0; a_cftw0 = 32'd0;
  endtask

  // One sclk period: data set with sclk low, sampled on the rising edge.
  task automatic send_unit(input logic [3:0] v);
    @(negedge clk); sclk = 1'b0; sdio = v;
    @(negedge clk); sclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (m_four) begin
      send_unit(b[7:4]);
      send_unit(b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) send_unit({3'b000, b[i]});
    end
  endtask

  task automatic cs_on();
    @(negedge clk); cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_off();
    @(negedge clk); sclk = 1'b0;
    @(negedge clk); cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] addr, input int n, input logic [31:0] val);
    logic [1:0] en;
    en = m_csr[7:6];
    send_byte({3'b000, addr});
    for (int i = n - 1; i >= 0; i--) send_byte(val[8*i +: 8]);
    case (addr)
      5'h00: begin m_csr = val[7:0]; m_four = (val[2:1] == 2'b11); end
      5'h01: b_fr1 = val[23:0];
      5'h03: begin if (en[0]) b_cfr0 = val[23:0]; if (en[1]) b_cfr1 = val[23:0]; end
      5'h04: begin if (en[0]) b_cftw0 = val; if (en[1]) b_cftw1 = val; end
      5'h05: begin if (en[0]) b_cpow0 = val[15:0]; if (en[1]) b_cpow1 = val[15:0]; end
      5'h06: begin if (en[0]) b_acr0 = val[23:0]; if (en[1]) b_acr1 = val[23:0]; end
      default: ;
    endcase
  endtask

  task automatic io_pulse();
    snap_t e;
    e.csr = m_csr; e.fr1 = b_fr1; e.cfr0 = b_cfr0; e.cfr1 = b_cfr1;
    e.cftw0 = b_cftw0; e.cftw1 = b_cftw1; e.cpow0 = b_cpow0; e.cpow1 = b_cpow1;
    e.acr0 = b_acr0; e.acr1 = b_acr1; e.four = m_four; e.perr = m_perr;
    a_cftw0 = b_cftw0;
    exp_q.push_back(e);
    pulses_sent++;
    @(negedge clk); io_update = 1'b1;
    @(negedge clk); io_update = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compare the active set against the scoreboard on every update_pulse.
  always @(negedge clk) begin
    if (update_pulse) begin
      pulses_seen++;
      chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got pulse expected none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("csr", {24'd0, csr}, {24'd0, mon_e.csr});
        chk("fr1", {8'd0, fr1}, {8'd0, mon_e.fr1});
        chk("cfr0", {8'd0, cfr0}, {8'd0, mon_e.cfr0});
        chk("cfr1", {8'd0, cfr1}, {8'd0, mon_e.cfr1});
        chk("cftw0", cftw0, mon_e.cftw0);
        chk("cftw1", cftw1, mon_e.cftw1);
        chk("cpow0", {16'd0, cpow0}, {16'd0, mon_e.cpow0});
        chk("cpow1", {16'd0, cpow1}, {16'd0, mon_e.cpow1});
        chk("acr0", {8'd0, acr0}, {8'd0, mon_e.acr0});
        chk("acr1", {8'd0, acr1}, {8'd0, mon_e.acr1});
        chk("four_bit_mode", {31'd0, four_bit_mode}, {31'd0, mon_e.four});
        chk("proto_error", {31'd0, proto_error}, {31'd0, mon_e.perr});
      end
    end
    prev_pulse = update_pulse;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetq = 1'b0; dds_reset = 1'b0; sclk = 1'b0; cs = 1'b1;
    sdio = 4'd0; io_update = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_csr", {24'd0, csr}, 32'h000000F0);
    chk("rst_cfr0", {8'd0, cfr0}, 32'h00000302);
    chk("rst_cfr1", {8'd0, cfr1}, 32'h00000302);
    chk("rst_fr1", {8'd0, fr1}, 32'd0);
    chk("rst_cftw0", cftw0, 32'd0);
    chk("rst_four", {31'd0, four_bit_mode}, 32'd0);
    chk("rst_pulse", {31'd0, update_pulse}, 32'd0);
    chk("rst_perr", {31'd0, proto_error}, 32'd0);

    // 1-bit mode, one cs window; ends by switching to 4-bit mode
    cs_on();
    write_reg(5'h01, 3, 32'h00930000);
    write_reg(5'h00, 1, 32'h000000C0);
    write_reg(5'h03, 3, 32'h00000320);
    write_reg(5'h00, 1, 32'h00000006);
    cs_off();
    chk("t1_csr_imm", {24'd0, csr}, 32'h00000006);
    chk("t1_four", {31'd0, four_bit_mode}, 32'd1);
    chk("t1_fr1_buffered", {8'd0, fr1}, 32'd0);
    io_pulse();

    // 4-bit mode, both channels
    cs_on();
    write_reg(5'h00, 1, 32'h00000046);
    write_reg(5'h04, 4, 32'hABCD1234);
    write_reg(5'h06, 3, 32'h000013FF);
    write_reg(5'h00, 1, 32'h00000086);
    write_reg(5'h04, 4, 32'hFEFE5A5A);
    write_reg(5'h06, 3, 32'h000010FF);
    cs_off();
    io_pulse();

    // Buffering: write without commit leaves the active value alone
    cs_on();
    write_reg(5'h00, 1, 32'h00000046);
    write_reg(5'h04, 4, 32'h11111111);
    cs_off();
    repeat (4) @(negedge clk);
    chk("buf_cftw0_held", cftw0, 32'hABCD1234);
    io_pulse();

    // Abort after 2 of 4 CFTW bytes
    cs_on();
    send_byte(8'h04);
    send_byte(8'h22);
    send_byte(8'h33);
    cs_off();
    io_pulse();
    chk("abort_perr", {31'd0, proto_error}, 32'd0);
    cs_on();
    write_reg(5'h04, 4, 32'h44556677);
    cs_off();
    io_pulse();

    // Invalid address 0x0A followed by data
    cs_on();
    send_byte(8'h0A);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    cs_off();
    m_perr = 1'b1;
    chk("err_perr", {31'd0, proto_error}, 32'd1);
    io_pulse();
    cs_on();
    write_reg(5'h05, 2, 32'h0000BEEF);
    cs_off();
    io_pulse();

    // dds_reset mid-transfer in 4-bit mode
    cs_on();
    send_byte(8'h04);
    send_byte(8'h99);
    @(negedge clk); dds_reset = 1'b1; sdio = 4'hF; sclk = 1'b1;
    repeat (2) @(negedge clk);
    sclk = 1'b0; dds_reset = 1'b0;
    model_reset();
    cs_off();
    chk("dr_csr", {24'd0, csr}, 32'h000000F0);
    chk("dr_four", {31'd0, four_bit_mode}, 32'd0);
    chk("dr_cfr0", {8'd0, cfr0}, 32'h00000302);
    chk("dr_cftw0", cftw0, 32'd0);
    chk("dr_perr", {31'd0, proto_error}, 32'd0);
    cs_on();
    write_reg(5'h00, 1, 32'h00000040);
    write_reg(5'h04, 4, 32'h0A0B0C0D);
    cs_off();
    chk("dr_csr_1bit", {24'd0, csr}, 32'h00000040);
    io_pulse();

    repeat (5) @(negedge clk);
    chk("pulse_count", pulses_seen, pulses_sent);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_serial_slave.md
Name: dds_serial_slave

Overview:
- Behavioural/synthesizable responder model for the AD9958 serial port: the receiving end of the DDS configuration stream driven by our DDS master.
- Decodes instruction bytes and register payloads in 1-bit and 4-bit serial modes. Holds per-channel buffered registers and commits them to active outputs on IO_UPDATE.
- Used in the simulation bench and as a loopback checker for the DDS init and frequency/amplitude update sequences.

Parameters:
- SCLK_MIN_PHASE, 1, minimum clk cycles per SCLK high/low phase the master guarantees; informational, used only by the assertion in Behaviour.

Ports:
- clk  in  1  system clock; all DDS-side inputs are synchronous to it
- resetq  in  1  asynchronous active-low reset
- dds_reset  in  1  DDS master reset, active-high, synchronous
- sclk  in  1  serial clock
- cs  in  1  chip select, active-low
- sdio  in  4  data; bit 0 used in 1-bit mode, nibble MSB on bit 3 in 4-bit mode
- io_update  in  1  commit strobe, rising-edge active
- csr  out  8  channel select register (immediate)
- fr1  out  24  active FR1
- cfr0, cfr1  out  24  active CFR, channel 0/1
- cftw0, cftw1  out  32  active frequency tuning word
- cpow0, cpow1  out  16  active phase offset word
- acr0, acr1  out  24  active amplitude control
- four_bit_mode  out  1  current serial mode (csr[2:1]==2'b11)
- update_pulse  out  1  one-cycle pulse per commit
- proto_error  out  1  sticky error flag; cleared by reset or dds_reset

Behaviour:
- Reset values (resetq low, or dds_reset high at a clk edge):
  - csr=8'hF0, cfr0/1=24'h000302, all other active and buffered registers 0.
  - four_bit_mode=0, update_pulse=0, proto_error=0, counters cleared, FSM in IDLE.
  - While dds_reset is high, all serial inputs are ignored.
- Edge detection:
  - sclk_q and io_update_q are registered.
  - SCLK rise = sclk & ~sclk_q & ~cs. Data is sampled from sdio in that same cycle.
- Shifting: MSB first.
  - 1-bit mode: 1 bit per rise from sdio[0].
  - 4-bit mode: nibble {sdio[3:0]} per rise.
  - A byte completes after 8 or 2 rises respectively.
- FSM:
  - IDLE: cs high. Counters are held at 0.
  - INSTR: on cs falling, or on completion of the previous register. The first byte is the instruction.
    - Bit 7 = read/write (1 = read). Bits 4:0 = address.
    - Lengths: 0x00→1, 0x01→3, 0x03→3, 0x04→4, 0x05→2, 0x06→3.
    - Any other address, or a read: set proto_error and go to DISCARD.
  - DATA: collect N bytes into a 32-bit assembly register.
    - After the last byte, write to the buffer and return to INSTR. Back-to-back registers within one cs-low window are legal.
  - DISCARD: ignore rises until cs goes high.
  - cs high in any state returns to IDLE. A partial byte or partial register is dropped with no buffer write and no error.
- Write targets:
  - CSR is written directly to the active csr at byte completion. The serial mode change applies from the next byte, within the same transaction.
  - FR1 goes to the shared buffer.
  - CFR/CFTW/CPOW/ACR go to the buffers of every channel whose enable bit was set at instruction-byte completion: csr[6]=ch0, csr[7]=ch1. Neither set: data is accepted and discarded, no error.
- Commit:
  - io_update & ~io_update_q, regardless of cs, copies all buffers to the active outputs at that clk edge.
  - update_pulse is high for exactly the following cycle.
  - If a register completes in the same cycle as the commit edge, its new value is included in the commit.
- Assertion (simulation only): an sclk phase shorter than SCLK_MIN_PHASE cycles sets proto_error.

Optional Feature:
- Macro DDS_SLAVE_READBACK_EN.
- Enabled: adds outputs sdo (1) and sdo_oe (1).
  - Read instructions to valid addresses enter READ state. The buffered value is shifted out MSB first on sdo, 1 bit per SCLK fall.
  - sdo_oe is high from instruction completion until cs goes high or N bytes are sent. Reads are legal in 1-bit mode only; a 4-bit read sets proto_error.
- Disabled: every read is a protocol error as above, and the ports do not exist.

Test Plan:
- 1-bit mode, one cs window:
  - Stimulus: 01 930000, 00 C0, 03 000320, 00 06, then io_update.
  - Response: fr1=24'h930000, cfr0=cfr1=24'h000320, csr=8'h06, four_bit_mode=1, one update_pulse.
- 4-bit mode, after the above:
  - Stimulus: 00 46, 04 ABCD1234, 06 0013FF, 00 86, 04 FEFE5A5A, 06 0010FF, then io_update.
  - Response: cftw0=32'hABCD1234, acr0=24'h0013FF, cftw1=32'hFEFE5A5A, acr1=24'h0010FF.
- Buffering:
  - Stimulus: write cftw0=32'h11111111 without io_update.
  - Response: cftw0 unchanged; it takes the new value only on the update_pulse cycle.
- Abort:
  - Stimulus: cs rises after 2 of the 4 CFTW bytes, then io_update.
  - Response: cftw0 keeps its prior value, proto_error=0, next transaction decodes normally.
- Error:
  - Stimulus: instruction 0x0A, followed by data.
  - Response: proto_error=1, no register changes; a subsequent valid write after cs toggles succeeds.
- dds_reset mid-transfer in 4-bit mode:
  - Response: csr=8'hF0, four_bit_mode=0, cfr0=24'h000302; the next 1-bit transaction decodes correctly.
